// File: rtl/shift_pkg.sv
// Shared types and widths for the shift_arb block (see SHIFT_ARB_ROTATE_EN in shift_core).
package shift_pkg;

    localparam int DATA_W = 4;
    localparam int SHL_W  = 2;

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_t;

endpackage

// File: rtl/shift_core.sv
// Combinational 4-bit left shifter built as a log-stage barrel.
// Define SHIFT_ARB_ROTATE_EN to rotate instead of zero-fill.
module shift_core
    import shift_pkg::*;
#(
    parameter int SHL_W_P = SHL_W
) (
    input  logic [DATA_W-1:0]  data,
    input  logic [SHL_W_P-1:0] shl,
    output logic [DATA_W-1:0]  result
);

    logic [DATA_W-1:0] stage [SHL_W_P+1];

    assign stage[0] = data;

    // Stage gi moves the word by 2**gi positions when shl[gi] is set.
    generate
        for (genvar gi = 0; gi < SHL_W_P; gi++) begin : g_stage
`ifdef SHIFT_ARB_ROTATE_EN
            localparam int AMT = (2 ** gi) % DATA_W;
            if (AMT == 0) begin : g_pass
                assign stage[gi+1] = stage[gi];
            end else begin : g_rot
                assign stage[gi+1] = shl[gi]
                    ? {stage[gi][DATA_W-1-AMT:0], stage[gi][DATA_W-1:DATA_W-AMT]}
                    : stage[gi];
            end
`else
            localparam int AMT = 2 ** gi;
            if (AMT >= DATA_W) begin : g_flush
                assign stage[gi+1] = shl[gi] ? '0 : stage[gi];
            end else begin : g_shl
                assign stage[gi+1] = shl[gi]
                    ? {stage[gi][DATA_W-1-AMT:0], {AMT{1'b0}}}
                    : stage[gi];
            end
`endif
        end
    endgenerate

    assign result = stage[SHL_W_P];

endmodule

// File: rtl/shift_arb.sv
// Two-requester round-robin arbiter sharing one shifter, with a one-entry output register.
// SHIFT_ARB_ROTATE_EN (in shift_core) selects rotate instead of zero-fill shift.
module shift_arb
    import shift_pkg::*;
#(
    parameter int RR_INIT = 0,
    parameter int SHL_W   = shift_pkg::SHL_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_data,
    input  logic [SHL_W-1:0]  req0_shl,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_data,
    input  logic [SHL_W-1:0]  req1_shl,
    output logic              req1_ready,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic              out_id,
    input  logic              out_ready,
    output logic              busy
);

    state_t            state_reg, state_next;
    logic              prio_reg, prio_next;
    logic [DATA_W-1:0] out_data_reg;
    logic              out_id_reg;

    logic              slot_open;
    logic              grant0, grant1, grant_any, grant_id;
    logic [DATA_W-1:0] sel_data, shifted;
    logic [SHL_W-1:0]  sel_shl;

    // Grants depend only on valids, state, priority and out_ready; rst_n gates them off in reset.
    always_comb begin
        state_next = state_reg;
        prio_next  = prio_reg;
        slot_open  = rst_n && ((state_reg == EMPTY) || out_ready);
        grant0     = slot_open && req0_valid && (!req1_valid || (prio_reg == 1'b0));
        grant1     = slot_open && req1_valid && (!req0_valid || (prio_reg == 1'b1));
        grant_any  = grant0 || grant1;
        grant_id   = grant1;

        if (grant_any) begin
            prio_next = ~grant_id;
        end

        case (state_reg)
            EMPTY: if (grant_any) state_next = FULL;
            FULL:  if (out_ready && !grant_any) state_next = EMPTY;
            default: state_next = EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= EMPTY;
            prio_reg  <= 1'(RR_INIT);
        end else begin
            state_reg <= state_next;
            prio_reg  <= prio_next;
        end
    end

    assign sel_data = grant_id ? req1_data : req0_data;
    assign sel_shl  = grant_id ? req1_shl  : req0_shl;

    shift_core #(
        .SHL_W_P (SHL_W)
    ) u_core (
        .data   (sel_data),
        .shl    (sel_shl),
        .result (shifted)
    );

    // The result register only moves on a grant, so it holds while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_reg <= '0;
            out_id_reg   <= 1'b0;
        end else if (grant_any) begin
            out_data_reg <= shifted;
            out_id_reg   <= grant_id;
        end
    end

    assign req0_ready = grant0;
    assign req1_ready = grant1;
    assign out_valid  = (state_reg == FULL);
    assign busy       = (state_reg == FULL);
    assign out_data   = out_data_reg;
    assign out_id     = out_id_reg;

endmodule

// File: tb/tb_shift_arb.sv
// Randomized scoreboard bench for shift_arb; honours SHIFT_ARB_ROTATE_EN when defined.
module tb_shift_arb;

    localparam int RR_INIT = 0;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       req0_valid, req1_valid;
    logic [3:0] req0_data,  req1_data;
    logic [1:0] req0_shl,   req1_shl;
    logic       req0_ready, req1_ready;
    logic       out_valid;
    logic [3:0] out_data;
    logic       out_id;
    logic       out_ready;
    logic       busy;

    typedef struct {
        logic [3:0] data;
        logic       id;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    bit   model_full;
    int   model_prio;

    shift_arb #(.RR_INIT(RR_INIT), .SHL_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req0_valid (req0_valid),
        .req0_data  (req0_data),
        .req0_shl   (req0_shl),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_data  (req1_data),
        .req1_shl   (req1_shl),
        .req1_ready (req1_ready),
        .out_valid  (out_valid),
        .out_data   (out_data),
        .out_id     (out_id),
        .out_ready  (out_ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    // Reference: multiply by 2**s; overflow is dropped, or wrapped back in when rotating.
    function automatic logic [3:0] ref_op(input int d, input int s);
        int p;
        p = d * (1 << s);
`ifdef SHIFT_ARB_ROTATE_EN
        return 4'((p % 16) + (p / 16));
`else
        return 4'(p % 16);
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model predicts grants and queues expected results.
    task automatic cycle(input logic v0, input logic [3:0] d0, input logic [1:0] s0,
                         input logic v1, input logic [3:0] d1, input logic [1:0] s1,
                         input logic o);
        bit open, g0, g1;
        @(posedge clk);
        #1;
        req0_valid = v0; req0_data = d0; req0_shl = s0;
        req1_valid = v1; req1_data = d1; req1_shl = s1;
        out_ready  = o;
        #1;
        open = !model_full || o;
        g0   = open && v0 && (!v1 || model_prio == 0);
        g1   = open && v1 && (!v0 || model_prio == 1);
        check("req0_ready", 32'(req0_ready), 32'(g0));
        check("req1_ready", 32'(req1_ready), 32'(g1));
        check("out_valid",  32'(out_valid),  32'(model_full));
        check("busy",       32'(busy),       32'(model_full));
        $display("cyc v=%0d%0d o=%0d grant0=%0d grant1=%0d full=%0d", v0, v1, o, g0, g1, model_full);
        if (g0) begin
            exp_q.push_back('{data: ref_op(int'(d0), int'(s0)), id: 1'b0});
            model_prio = 1;
        end
        if (g1) begin
            exp_q.push_back('{data: ref_op(int'(d1), int'(s1)), id: 1'b1});
            model_prio = 0;
        end
        model_full = g0 || g1 || (model_full && !o);
    endtask

    task automatic idle_cycle(input logic o);
        cycle(1'b0, 4'h0, 2'd0, 1'b0, 4'h0, 2'd0, o);
    endtask

    // Mid-flight reset: outputs must clear at once and the held result is gone.
    task automatic reset_pulse();
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        req0_valid = 1'b1;
        req1_valid = 1'b1;
        out_ready  = 1'b1;
        #1;
        check("rst out_valid",  32'(out_valid),  32'd0);
        check("rst busy",       32'(busy),       32'd0);
        check("rst out_data",   32'(out_data),   32'd0);
        check("rst out_id",     32'(out_id),     32'd0);
        check("rst req0_ready", 32'(req0_ready), 32'd0);
        check("rst req1_ready", 32'(req1_ready), 32'd0);
        exp_q.delete();
        model_full = 1'b0;
        model_prio = RR_INIT;
        repeat (2) @(posedge clk);
        #1;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        rst_n      = 1'b1;
    endtask

    // Monitor: whenever a result is presented it must match the oldest expectation.
    always @(negedge clk) begin
        if (rst_n && out_valid) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_result: got data=%0h id=%0d expected none", out_data, out_id);
            end else begin
                check("out_data", 32'(out_data), 32'(exp_q[0].data));
                check("out_id",   32'(out_id),   32'(exp_q[0].id));
                if (out_ready) begin
                    $display("out data=%0h id=%0d", out_data, out_id);
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst_n = 1'b0;
        req0_valid = 1'b1; req0_data = 4'h5; req0_shl = 2'd1;
        req1_valid = 1'b1; req1_data = 4'hA; req1_shl = 2'd2;
        out_ready  = 1'b1;
        model_full = 1'b0;
        model_prio = RR_INIT;
        #12;
        check("init out_valid",  32'(out_valid),  32'd0);
        check("init out_data",   32'(out_data),   32'd0);
        check("init out_id",     32'(out_id),     32'd0);
        check("init busy",       32'(busy),       32'd0);
        check("init req0_ready", 32'(req0_ready), 32'd0);
        check("init req1_ready", 32'(req1_ready), 32'd0);
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Both valid every cycle: grants alternate from RR_INIT, output never drops.
        for (int i = 0; i < 8; i++) begin
            cycle(1'b1, 4'(i), 2'(i), 1'b1, 4'(15 - i), 2'(3 - i), 1'b1);
        end
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Single request 0011 << 1.
        cycle(1'b1, 4'b0011, 2'd1, 1'b0, 4'h0, 2'd0, 1'b1);
        idle_cycle(1'b1);
        check("direct 0011<<1 data", 32'(out_data), 32'(4'b0110));
        check("direct 0011<<1 id",   32'(out_id),   32'd0);

        // req1 1001 << 3 held for three stalled cycles while both requesters wait.
        cycle(1'b0, 4'h0, 2'd0, 1'b1, 4'b1001, 2'd3, 1'b0);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b1, 4'h7, 2'd2, 1'b1, 4'h3, 2'd1, 1'b0);
        end
`ifdef SHIFT_ARB_ROTATE_EN
        check("held 1001 rot3", 32'(out_data), 32'(4'b1100));
`else
        check("held 1001 shl3", 32'(out_data), 32'(4'b1000));
`endif
        idle_cycle(1'b1);
        idle_cycle(1'b1);

        // Rotate/shift of 1010 by 1 and shl 0 pass-through.
        cycle(1'b1, 4'b1010, 2'd1, 1'b0, 4'h0, 2'd0, 1'b1);
        cycle(1'b0, 4'h0, 2'd0, 1'b1, 4'b1101, 2'd0, 1'b1);
        idle_cycle(1'b1);

        // Four req0-only grants, then both valid: req1 must win first.
        for (int i = 0; i < 4; i++) begin
            cycle(1'b1, 4'(i + 3), 2'(i), 1'b0, 4'h0, 2'd0, 1'b1);
        end
        cycle(1'b1, 4'h6, 2'd1, 1'b1, 4'h9, 2'd2, 1'b1);
        cycle(1'b1, 4'h6, 2'd1, 1'b1, 4'h9, 2'd2, 1'b1);

        // Reset while FULL and stalled; afterwards no stale result and priority restored.
        cycle(1'b0, 4'h0, 2'd0, 1'b1, 4'hF, 2'd1, 1'b0);
        idle_cycle(1'b0);
        reset_pulse();
        idle_cycle(1'b1);
        idle_cycle(1'b1);
        cycle(1'b1, 4'h1, 2'd3, 1'b1, 4'h2, 2'd2, 1'b1);
        idle_cycle(1'b1);

        for (int i = 0; i < 300; i++) begin
            cycle(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), 2'($urandom_range(0, 3)),
                  1'($urandom_range(0, 3) != 0));
        end

        for (int i = 0; i < 4; i++) begin
            idle_cycle(1'b1);
        end
        @(negedge clk);
        check("queue drained", 32'(exp_q.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
